drive_cmd_conditioner: RTL and testbench

DRIVE_CMD_CONDITIONER -- requirements
Module: drive_cmd_conditioner

---
 rtl/drive_pkg.sv | 38 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/drive_cmd_conditioner.sv | 112 +++++++++++
 tb/tb_drive_cmd_conditioner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared definitions for the drive command path: FSM states and the 3-bit
// command codes understood by the downstream driving FSM.
package drive_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'b000,
        CMD_RIGHT    = 3'b001,
        CMD_LEFT     = 3'b010,
        CMD_STRAIGHT = 3'b011,
        CMD_BACK     = 3'b100
    } cmd_t;

    // Press vector order is {straight, right, left, back}; bit 3 has top priority.
    function automatic cmd_t pick_cmd(input logic [3:0] presses);
        if (presses[3])      return CMD_STRAIGHT;
        else if (presses[2]) return CMD_RIGHT;
        else if (presses[1]) return CMD_LEFT;
        else if (presses[0]) return CMD_BACK;
        else                 return CMD_NONE;
    endfunction

    function automatic logic [3:0] cmd_onehot(input cmd_t cmd);
        case (cmd)
            CMD_STRAIGHT: return 4'b1000;
            CMD_RIGHT:    return 4'b0100;
            CMD_LEFT:     return 4'b0010;
            CMD_BACK:     return 4'b0001;
            default:      return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, stability-count debouncer and a
// registered single-cycle press pulse on a debounced 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 5
) (
    input  logic clk_100hz,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_TICKS < 1) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_100hz) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value; blocking here would collapse the synchronizer chain.
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEBOUNCE_TICKS - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/drive_cmd_conditioner.sv
// Turns four raw buttons into single, rate-limited drive commands.
// Build option CMD_HOLD_EN: hold the issued command high through lockout.
module drive_cmd_conditioner
    import drive_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 5,
    parameter int LOCKOUT_TICKS  = 100
) (
    input  logic       clk_100hz,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_straight,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_back,
    output logic       go_straight_command,
    output logic       turn_right_command,
    output logic       turn_left_command,
    output logic       turn_back_command,
    output logic [2:0] cmd_code,
    output logic       lockout_active
);
    localparam int LW = (LOCKOUT_TICKS < 1) ? 1 : $clog2(LOCKOUT_TICKS + 1);

    logic [3:0]    press_vec;
    state_t        state, state_next;
    cmd_t          cmd_lat, cmd_next;
    logic [LW-1:0] lock_cnt;
    logic          cmd_active;
    logic [3:0]    cmds_d;
    logic [2:0]    code_d;
    logic          lockout_d;

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_straight (
        .clk_100hz(clk_100hz), .reset(reset), .btn(btn_straight), .press(press_vec[3]));
    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_right (
        .clk_100hz(clk_100hz), .reset(reset), .btn(btn_right), .press(press_vec[2]));
    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_left (
        .clk_100hz(clk_100hz), .reset(reset), .btn(btn_left), .press(press_vec[1]));
    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_back (
        .clk_100hz(clk_100hz), .reset(reset), .btn(btn_back), .press(press_vec[0]));

    always_ff @(posedge clk_100hz) begin
        if (reset) begin
            state    <= ST_IDLE;
            cmd_lat  <= CMD_NONE;
            lock_cnt <= '0;
        end else begin
            state   <= state_next;
            cmd_lat <= cmd_next;
            if (state != ST_LOCKOUT)
                lock_cnt <= '0;
            else if (lock_cnt < LW'(LOCKOUT_TICKS - 1))
                lock_cnt <= lock_cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise synthesis infers latches.
        state_next = state;
        cmd_next   = cmd_lat;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|press_vec) begin
                        state_next = ST_ISSUE;
                        cmd_next   = pick_cmd(press_vec);
                    end
                end
                ST_ISSUE:   state_next = ST_LOCKOUT;
                ST_LOCKOUT: begin
                    if (lock_cnt >= LW'(LOCKOUT_TICKS - 1))
                        state_next = ST_IDLE;
                end
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with the state.
    always_comb begin
`ifdef CMD_HOLD_EN
        cmd_active = (state_next == ST_ISSUE) || (state_next == ST_LOCKOUT);
`else
        cmd_active = (state_next == ST_ISSUE);
`endif
        cmds_d    = cmd_active ? cmd_onehot(cmd_next) : 4'b0000;
        code_d    = (state_next == ST_ISSUE) ? cmd_next : cmd_code;
        lockout_d = (state_next == ST_LOCKOUT);
    end

    always_ff @(posedge clk_100hz) begin
        if (reset) begin
            go_straight_command <= 1'b0;
            turn_right_command  <= 1'b0;
            turn_left_command   <= 1'b0;
            turn_back_command   <= 1'b0;
            cmd_code            <= CMD_NONE;
            lockout_active      <= 1'b0;
        end else begin
            go_straight_command <= cmds_d[3];
            turn_right_command  <= cmds_d[2];
            turn_left_command   <= cmds_d[1];
            turn_back_command   <= cmds_d[0];
            cmd_code            <= code_d;
            lockout_active      <= lockout_d;
        end
    end

endmodule

// File: tb/tb_drive_cmd_conditioner.sv
// Directed self-checking bench for drive_cmd_conditioner (default parameters).
// Cycle k below means the value observed just after the k-th edge that samples the stimulus.
module tb_drive_cmd_conditioner;

    logic       clk_100hz = 1'b0;
    logic       reset, enable;
    logic       btn_straight, btn_right, btn_left, btn_back;
    logic       go_straight_command, turn_right_command, turn_left_command, turn_back_command;
    logic [2:0] cmd_code;
    logic       lockout_active;
    logic [3:0] cmd_bus;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_100hz = ~clk_100hz;

    assign cmd_bus = {go_straight_command, turn_right_command, turn_left_command, turn_back_command};

    drive_cmd_conditioner #(.DEBOUNCE_TICKS(5), .LOCKOUT_TICKS(100)) dut (
        .clk_100hz(clk_100hz),
        .reset(reset),
        .enable(enable),
        .btn_straight(btn_straight),
        .btn_right(btn_right),
        .btn_left(btn_left),
        .btn_back(btn_back),
        .go_straight_command(go_straight_command),
        .turn_right_command(turn_right_command),
        .turn_left_command(turn_left_command),
        .turn_back_command(turn_back_command),
        .cmd_code(cmd_code),
        .lockout_active(lockout_active)
    );

    task automatic tick();
        @(posedge clk_100hz);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected command bus at cycle k for a command issued at cycle t.
    function automatic logic [3:0] exp_cmd(input int k, input int t, input logic [3:0] v);
`ifdef CMD_HOLD_EN
        return (k >= t && k <= t + 100) ? v : 4'b0000;
`else
        return (k == t) ? v : 4'b0000;
`endif
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0;
        btn_straight = 1'b0; btn_right = 1'b0; btn_left = 1'b0; btn_back = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cmds", 8'(cmd_bus), 8'h0);
        check("rst_code", 8'(cmd_code), 8'h0);
        check("rst_lock", 8'(lockout_active), 8'h0);
        reset = 1'b0; enable = 1'b1;
        repeat (3) tick();

        // Right held 20 cycles: strobe at 8, lockout 9..108
        btn_right = 1'b1;
        for (int k = 0; k <= 110; k++) begin
            tick();
            check("right_cmd", 8'(cmd_bus), 8'(exp_cmd(k, 8, 4'b0100)));
            check("right_lock", 8'(lockout_active), 8'((k >= 9 && k <= 108) ? 1 : 0));
            if (k == 7) check("right_code_pre", 8'(cmd_code), 8'h0);
            if (k == 8) check("right_code", 8'(cmd_code), 8'h1);
            if (k == 19) btn_right = 1'b0;
        end
        repeat (5) tick();

        // Left bouncing: 3 high / 3 low, ten times -> nothing
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 6; c++) begin
                btn_left = (c < 3);
                tick();
                check("bounce_cmd", 8'(cmd_bus), 8'h0);
            end
        end
        btn_left = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bounce_tail", 8'(cmd_bus | {3'b0, lockout_active}), 8'h0);
        end

        // Left and back together: left wins
        btn_left = 1'b1; btn_back = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            check("prio_cmd", 8'(cmd_bus), 8'(exp_cmd(k, 8, 4'b0010)));
        end
        check("prio_code", 8'(cmd_code), 8'h2);
        btn_left = 1'b0; btn_back = 1'b0;
        repeat (110) tick();
        check("prio_idle", 8'(lockout_active), 8'h0);

        // Straight issued; back pressed mid-lockout is discarded
        btn_straight = 1'b1;
        for (int k = 0; k <= 115; k++) begin
            tick();
            check("lock_cmd", 8'(cmd_bus), 8'(exp_cmd(k, 8, 4'b1000)));
            if (k == 10) btn_straight = 1'b0;
            if (k == 49) btn_back = 1'b1;
            if (k == 59) btn_back = 1'b0;
        end
        check("lock_code", 8'(cmd_code), 8'h3);
        check("lock_done", 8'(lockout_active), 8'h0);
        btn_back = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            check("repress_cmd", 8'(cmd_bus), 8'(exp_cmd(k, 8, 4'b0001)));
        end
        check("repress_code", 8'(cmd_code), 8'h4);
        btn_back = 1'b0;
        repeat (110) tick();

        // Reset mid-lockout with straight held, then enable drop
        btn_straight = 1'b1;
        for (int k = 0; k <= 58; k++) begin
            tick();
            check("pre_rst_cmd", 8'(cmd_bus), 8'(exp_cmd(k, 8, 4'b1000)));
        end
        check("pre_rst_lock", 8'(lockout_active), 8'h1);
        reset = 1'b1;
        tick();
        check("mid_rst_cmds", 8'(cmd_bus), 8'h0);
        check("mid_rst_lock", 8'(lockout_active), 8'h0);
        check("mid_rst_code", 8'(cmd_code), 8'h0);
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            check("post_rst_cmd", 8'(cmd_bus), 8'(exp_cmd(k, 8, 4'b1000)));
            check("post_rst_lock", 8'(lockout_active), 8'((k >= 9) ? 1 : 0));
        end
        enable = 1'b0;
        tick();
        check("dis_cmds", 8'(cmd_bus), 8'h0);
        check("dis_lock", 8'(lockout_active), 8'h0);
        check("dis_code", 8'(cmd_code), 8'h3);
        enable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("held_no_reissue", 8'(cmd_bus | {3'b0, lockout_active}), 8'h0);
        end
        btn_straight = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
